// File: rtl/hazard_scheduler.sv
// hazard_scheduler
// ----------------
// Pipeline hazard controller for the 5-stage MIPS32 core. It sits beside
// ID-stage decode, spots load-use, beq and j hazards, and sequences the
// resulting stalls and flushes.
//
// Parameters:
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (1..15)
//   BRANCH_TIMEOUT     BR_WAIT cycles allowed before Branch_Error sets (2..255)
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset            asynchronous, active-high reset
//   Opcode_ID        Instruction_ID[31:26] in decode
//   Rs_ID, Rt_ID     source register fields in decode
//   MemRead_EX       instruction in EX is a lw
//   Rt_EX            destination rt of the instruction in EX
//   Branch_Resolved  one-cycle pulse: beq outcome final, PC mux valid
//   PC_Write         PC register load enable
//   IF_ID_Write      IF/ID register load enable
//   IF_Flush         IF/ID loads a nop on this edge
//   ID_Control_NOP   force nop control signals in ID
//   Branch_Error     sticky branch-timeout flag, cleared only by reset
//   Sched_State      current state (RUN=0, LOAD_STALL=1, BR_WAIT=2)
//
// Optional build macro HAZARD_PERF_CNT_EN adds two saturating 16-bit
// counters, Stall_Cycles and Flush_Cycles. Without it those ports do not
// exist and everything else behaves identically.

module hazard_scheduler #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_TIMEOUT    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode_ID,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic        MemRead_EX,
    input  logic [4:0]  Rt_EX,
    input  logic        Branch_Resolved,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_Flush,
    output logic        ID_Control_NOP,
    output logic        Branch_Error,
    output logic [1:0]  Sched_State
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] Stall_Cycles,
    output logic [15:0] Flush_Cycles
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JUMP  = 6'b000010;

    // The RUN cycle that detects the hazard is the first bubble, so the
    // LOAD_STALL state only has to cover the remaining LOAD_STALL_CYCLES-1.
    localparam logic [3:0] STALL_INIT  =
        (LOAD_STALL_CYCLES >= 2) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
    localparam logic [7:0] TIMEOUT_LIM = 8'(BRANCH_TIMEOUT);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_WAIT    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] timeout_cnt_q, timeout_cnt_d;
    logic       branch_error_q, branch_error_d;
    logic       load_use;

    // rt is only a true source operand for R-type, sw and beq; every other
    // opcode reads rs alone.
    always_comb begin
        load_use = MemRead_EX && (Rt_EX != 5'd0) &&
                   ((Rt_EX == Rs_ID) ||
                    ((Rt_EX == Rt_ID) &&
                     ((Opcode_ID == OP_RTYPE) || (Opcode_ID == OP_SW) ||
                      (Opcode_ID == OP_BEQ))));
    end

    always_comb begin
        state_d        = state_q;
        stall_cnt_d    = stall_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        branch_error_d = branch_error_q;
        PC_Write       = 1'b1;
        IF_ID_Write    = 1'b1;
        IF_Flush       = 1'b0;
        ID_Control_NOP = 1'b0;

        case (state_q)
            RUN: begin
                if (load_use) begin
                    PC_Write       = 1'b0;
                    IF_ID_Write    = 1'b0;
                    ID_Control_NOP = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d     = LOAD_STALL;
                        stall_cnt_d = STALL_INIT;
                    end
                end else if (Opcode_ID == OP_BEQ) begin
                    // beq itself proceeds to EX; fetch is frozen from next cycle.
                    state_d       = BR_WAIT;
                    timeout_cnt_d = 8'd0;
                end else if (Opcode_ID == OP_JUMP) begin
                    IF_Flush = 1'b1;
                end
            end

            LOAD_STALL: begin
                PC_Write       = 1'b0;
                IF_ID_Write    = 1'b0;
                ID_Control_NOP = 1'b1;
                if (stall_cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    stall_cnt_d = stall_cnt_q - 4'd1;
                end
            end

            BR_WAIT: begin
                // PC loads only once the datapath has picked target or PC+4.
                PC_Write       = Branch_Resolved;
                IF_Flush       = 1'b1;
                ID_Control_NOP = 1'b1;
                timeout_cnt_d  = (timeout_cnt_q == 8'hFF) ? timeout_cnt_q
                                                          : timeout_cnt_q + 8'd1;
                if (Branch_Resolved) begin
                    state_d = RUN;
                end else if (timeout_cnt_d >= TIMEOUT_LIM) begin
                    branch_error_d = 1'b1;
                    state_d        = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        // Keep the pipeline at its idle enables while reset is held, even if
        // decode happens to present a hazard pattern.
        if (reset) begin
            PC_Write       = 1'b1;
            IF_ID_Write    = 1'b1;
            IF_Flush       = 1'b0;
            ID_Control_NOP = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            stall_cnt_q    <= 4'd0;
            timeout_cnt_q  <= 8'd0;
            branch_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cnt_q    <= stall_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            branch_error_q <= branch_error_d;
        end
    end

    assign Branch_Error = branch_error_q;
    assign Sched_State  = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_cycles_q, flush_cycles_d;

    // Flush cycles also assert ID_Control_NOP, so they are excluded from the
    // stall count to keep the two counters disjoint.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (ID_Control_NOP && !IF_Flush && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (IF_Flush && (flush_cycles_q != 16'hFFFF)) begin
            flush_cycles_d = flush_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
            flush_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign Stall_Cycles = stall_cycles_q;
    assign Flush_Cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler. Two instances share one stimulus
// stream: u_dut1 (LOAD_STALL_CYCLES=1, BRANCH_TIMEOUT=8) and u_dut3
// (LOAD_STALL_CYCLES=3, BRANCH_TIMEOUT=5). Each cycle the stimulus task
// drives inputs, asks the reference model for the expected outputs and
// queues them; an independent monitor pops and compares.

module tb_hazard_scheduler;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JUMP  = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [4:0] rs, rt, rt_ex;
    logic       mem_read, resolved;

    logic       pcw1, ifid1, fl1, nop1, err1;
    logic [1:0] st1;
    logic       pcw3, ifid3, fl3, nop3, err3;
    logic [1:0] st3;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
    int          m_stall[2];
    int          m_flush[2];
`endif

    int vectors;
    int miscompares;

    // Expected output word: {state[1:0], err, pc_write, ifid_write, flush, nop}
    logic [6:0] exp_q1[$];
    logic [6:0] exp_q3[$];

    // Reference model state: current mode, bubbles still owed, cycles spent
    // waiting on a branch, sticky error.
    int m_mode[2];
    int m_left[2];
    int m_waited[2];
    bit m_err[2];
    int lsc[2] = '{1, 3};
    int bt[2]  = '{8, 5};

    hazard_scheduler #(.LOAD_STALL_CYCLES(1), .BRANCH_TIMEOUT(8)) u_dut1 (
        .clk(clk), .reset(reset), .Opcode_ID(opcode), .Rs_ID(rs), .Rt_ID(rt),
        .MemRead_EX(mem_read), .Rt_EX(rt_ex), .Branch_Resolved(resolved),
        .PC_Write(pcw1), .IF_ID_Write(ifid1), .IF_Flush(fl1),
        .ID_Control_NOP(nop1), .Branch_Error(err1), .Sched_State(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Cycles(stall_cnt1), .Flush_Cycles(flush_cnt1)
`endif
    );

    hazard_scheduler #(.LOAD_STALL_CYCLES(3), .BRANCH_TIMEOUT(5)) u_dut3 (
        .clk(clk), .reset(reset), .Opcode_ID(opcode), .Rs_ID(rs), .Rt_ID(rt),
        .MemRead_EX(mem_read), .Rt_EX(rt_ex), .Branch_Resolved(resolved),
        .PC_Write(pcw3), .IF_ID_Write(ifid3), .IF_Flush(fl3),
        .ID_Control_NOP(nop3), .Branch_Error(err3), .Sched_State(st3)
`ifdef HAZARD_PERF_CNT_EN
        , .Stall_Cycles(stall_cnt3), .Flush_Cycles(flush_cnt3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit loadUse();
        bit uses_rt;
        uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
        return mem_read && (rt_ex != 5'd0) &&
               ((rt_ex == rs) || (uses_rt && (rt_ex == rt)));
    endfunction

    // Expected outputs for instance k during the current cycle.
    function automatic logic [6:0] modelOut(int k);
        bit pcw = 1'b1, ifid = 1'b1, fl = 1'b0, nop = 1'b0;
        if (reset) return 7'b00_0_1_1_0_0;
        if (m_mode[k] == 0) begin
            if (loadUse()) begin
                pcw = 1'b0; ifid = 1'b0; nop = 1'b1;
            end else if (opcode == OP_JUMP) begin
                fl = 1'b1;
            end
        end else if (m_mode[k] == 1) begin
            pcw = 1'b0; ifid = 1'b0; nop = 1'b1;
        end else begin
            pcw = resolved; fl = 1'b1; nop = 1'b1;
        end
        return {2'(m_mode[k]), m_err[k], pcw, ifid, fl, nop};
    endfunction

    // Advance instance k across the coming rising edge.
    function automatic void modelStep(int k);
        if (reset) begin
            m_mode[k] = 0; m_left[k] = 0; m_waited[k] = 0; m_err[k] = 1'b0;
            return;
        end
        case (m_mode[k])
            0: begin
                if (loadUse()) begin
                    if (lsc[k] > 1) begin
                        m_mode[k] = 1;
                        m_left[k] = lsc[k] - 1;
                    end
                end else if (opcode == OP_BEQ) begin
                    m_mode[k]   = 2;
                    m_waited[k] = 0;
                end
            end
            1: begin
                m_left[k]--;
                if (m_left[k] == 0) m_mode[k] = 0;
            end
            default: begin
                m_waited[k]++;
                if (resolved) m_mode[k] = 0;
                else if (m_waited[k] >= bt[k]) begin
                    m_err[k]  = 1'b1;
                    m_mode[k] = 0;
                end
            end
        endcase
    endfunction

    // Drive one cycle of inputs and queue what each instance should show.
    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] f_rs,
                                 input logic [4:0] f_rt, input logic mr,
                                 input logic [4:0] f_rtex, input logic res,
                                 input logic rst);
        logic [6:0] e;
        @(negedge clk);
        opcode = op; rs = f_rs; rt = f_rt; mem_read = mr;
        rt_ex = f_rtex; resolved = res; reset = rst;
        for (int k = 0; k < 2; k++) begin
            e = modelOut(k);
            if (k == 0) exp_q1.push_back(e);
            else        exp_q3.push_back(e);
`ifdef HAZARD_PERF_CNT_EN
            if (reset) begin
                m_stall[k] = 0; m_flush[k] = 0;
            end else begin
                if (e[0] && !e[1] && m_stall[k] < 65535) m_stall[k]++;
                if (e[1] && m_flush[k] < 65535) m_flush[k]++;
            end
`endif
            modelStep(k);
        end
    endtask

    task automatic idle(input int n, input logic res = 1'b0);
        for (int i = 0; i < n; i++)
            applyStimulus(OP_ADDI, 5'd1, 5'd2, 1'b0, 5'd0, res, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [6:0] exp,
                               input logic [6:0] act);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got state=%0d err=%b pcw=%b ifid=%b flush=%b nop=%b, expected state=%0d err=%b pcw=%b ifid=%b flush=%b nop=%b",
                     name, $time, act[6:5], act[4], act[3], act[2], act[1], act[0],
                     exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: samples mid-cycle, well clear of the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (exp_q1.size() > 0)
                checkOutput("dut_lsc1", exp_q1.pop_front(), {st1, err1, pcw1, ifid1, fl1, nop1});
            while (exp_q3.size() > 0)
                checkOutput("dut_lsc3", exp_q3.pop_front(), {st3, err3, pcw3, ifid3, fl3, nop3});
        end
    end

    initial begin
        logic [5:0] ops[6];
        vectors = 0; miscompares = 0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_left[k] = 0; m_waited[k] = 0; m_err[k] = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
            m_stall[k] = 0; m_flush[k] = 0;
`endif
        end
        reset = 1'b1; opcode = OP_ADDI; rs = 5'd1; rt = 5'd2;
        mem_read = 1'b0; rt_ex = 5'd0; resolved = 1'b0;

        // Reset state, then idle running.
        applyStimulus(OP_ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
        applyStimulus(OP_ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(2);

        // R-type load-use on rt: one bubble on dut1, three on dut3.
        applyStimulus(OP_RTYPE, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        idle(4);
        // Same pattern with Rt_EX=0: never a hazard.
        applyStimulus(OP_RTYPE, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        idle(1);
        // lw in ID only reads rs, so an rt match is not a hazard.
        applyStimulus(OP_LW, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        // I-type rs match is a hazard.
        applyStimulus(OP_ADDI, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0);
        idle(4);

        // beq resolved two cycles after it leaves ID.
        applyStimulus(OP_BEQ, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(1);
        idle(1, 1'b1);
        idle(2);

        // beq that never resolves: both instances time out and stay flagged.
        applyStimulus(OP_BEQ, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(10);
        idle(2);
        applyStimulus(OP_JUMP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(1);

        // Reset in the middle of BR_WAIT takes effect before the next edge.
        applyStimulus(OP_BEQ, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(2);
        applyStimulus(OP_ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(2);

        // Load-use and beq together: stall first, then BR_WAIT.
        applyStimulus(OP_BEQ, 5'd4, 5'd6, 1'b1, 5'd4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(OP_BEQ, 5'd4, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(3, 1'b1);
        idle(2);

        // Randomised traffic with narrow register ranges to force collisions.
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_JUMP, OP_ADDI};
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            applyStimulus(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 63) == 0));
        end

        @(negedge clk);
        #3;
        if (exp_q1.size() != 0 || exp_q3.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0",
                     exp_q1.size(), exp_q3.size());
        end
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_counters_lsc1", 7'(m_stall[0] == int'(stall_cnt1)) << 1 | 7'(m_flush[0] == int'(flush_cnt1)), 7'b0000011);
        checkOutput("perf_counters_lsc3", 7'(m_stall[1] == int'(stall_cnt3)) << 1 | 7'(m_flush[1] == int'(flush_cnt3)), 7'b0000011);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
